// File: rtl/rf_pow_sequencer.sv
// RF power monitor channel sequencer.
// Steps the MUX, settles, gathers n ADC samples, emits one sum per dwell.
module rf_pow_sequencer #(
    parameter int SETTLE_CYC = 64,
    parameter int ACC_W      = 26
) (
    input  logic             CLK,
    input  logic             rst_i,
    input  logic             enable,
    input  logic [7:0]       ch_mask,
    input  logic [15:0]      n_samples,
    output logic             conv_req,
    input  logic             conv_ack,
    input  logic [11:0]      conv_data,
    output logic [2:0]       mux_sel,
    output logic             wr_stb,
    output logic [2:0]       wr_ch,
    output logic [ACC_W-1:0] wr_sum,
    output logic             wr_phase,
    output logic             busy
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [15:0]      count;
    logic [15:0]      n_lat;
    logic [SW-1:0]    scnt;
    logic             first;

    logic [2:0]       nxt_ch;
    logic [2:0]       cand;
    logic             found;
    logic             wrap;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_sat;

    // Round-robin search: after the current channel, current one last.
    always_comb begin
        nxt_ch = mux_sel;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = first ? 3'(i) : mux_sel + 3'(i + 1);
            if (!found && ch_mask[cand]) begin
                nxt_ch = cand;
                found  = 1'b1;
            end
        end
        wrap = !first && (nxt_ch <= mux_sel);
    end

    // Saturating accumulate of the incoming sample.
    always_comb begin
        sum_ext = {1'b0, acc} + (ACC_W + 1)'(conv_data);
        acc_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end

    assign busy = (state != S_IDLE);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge CLK or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            mux_sel  <= '0;
            conv_req <= 1'b0;
            wr_stb   <= 1'b0;
            wr_ch    <= '0;
            wr_sum   <= '0;
            wr_phase <= 1'b0;
            acc      <= '0;
            count    <= '0;
            n_lat    <= 16'd1;
            scnt     <= '0;
            first    <= 1'b1;
        end else begin
            wr_stb <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (enable && |ch_mask)
                        state <= S_SELECT;
                end
                S_SELECT: begin
                    if (|ch_mask) begin
                        mux_sel <= nxt_ch;
                        if (wrap)
                            wr_phase <= ~wr_phase;
                        n_lat <= (n_samples == 16'd0) ? 16'd1 : n_samples;
                        acc   <= '0;
                        count <= '0;
                        first <= 1'b0;
                        scnt  <= '0;
                        state <= S_SETTLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (scnt == SW'(SETTLE_CYC)) begin
                        state    <= S_REQ;
                        conv_req <= 1'b1;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (conv_ack) begin
                        acc      <= acc_sat;
                        count    <= count + 16'd1;
                        conv_req <= 1'b0;
                        state    <= S_WAIT;
                    end else if (!enable) begin
                        conv_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (count == n_lat) begin
                        wr_stb <= 1'b1;
                        wr_ch  <= mux_sel;
                        wr_sum <= acc;
                        state  <= S_DONE;
                    end else if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        conv_req <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_DONE: begin
                    state <= enable ? S_SELECT : S_IDLE;
                end
                default: begin
                    conv_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
